// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and colour from a raw VGA sync/colour stream and locks onto its timing.
// Optional error statistics (err_count port) are built when VGA_DEC_STATS_EN is defined.
module vga_sync_decoder #(
    parameter int H_ACTIVE = 640,
    parameter int H_BP     = 48,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_BP     = 33,
    parameter int V_TOTAL  = 525
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [3:0] pix_red,
    output logic [3:0] pix_green,
    output logic [3:0] pix_blue,
    output logic       frame_start,
    output logic       locked,
    output logic [9:0] line_len
`ifdef VGA_DEC_STATS_EN
    ,
    output logic [7:0] err_count
`endif
);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t     state;
    logic       hs_r, vs_r, hs_d, vs_d;
    logic [3:0] red_r, green_r, blue_r;
    logic [9:0] h_cnt, v_cnt;
    logic       first_done;
    logic       mflag;
    logic       vis1;
    logic [9:0] x1, y1;

    logic        h_edge, v_edge;
    logic [9:0]  h_len;
    logic [10:0] h_ext, v_ext, v_next;
    logic        h_vis, v_vis;
    logic        len_bad, frame_bad, lock_fail, out_ok;

    // Deassert edges are low->high transitions of the registered syncs.
    assign h_edge    = hs_r & ~hs_d;
    assign v_edge    = vs_r & ~vs_d;
    assign h_len     = (h_cnt == 10'h3FF) ? h_cnt : h_cnt + 10'd1;
    assign h_ext     = {1'b0, h_cnt};
    assign v_ext     = {1'b0, v_cnt};
    assign v_next    = v_ext + 11'd1;
    assign h_vis     = (h_ext >= 11'(H_BP)) && (h_ext < 11'(H_BP + H_ACTIVE));
    assign v_vis     = (v_ext >= 11'(V_BP)) && (v_ext < 11'(V_BP + V_ACTIVE));
    // The first measured line after reset starts from an arbitrary point, so it never counts as bad.
    assign len_bad   = h_edge && first_done && (h_len != 10'(H_TOTAL));
    assign frame_bad = v_edge && (v_next != 11'(V_TOTAL));
    assign lock_fail = (state == LOCKED) && (len_bad || frame_bad);
    assign out_ok    = vis1 && (state == LOCKED) && !lock_fail;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_r       <= 1'b0;
            vs_r       <= 1'b0;
            hs_d       <= 1'b0;
            vs_d       <= 1'b0;
            red_r      <= 4'd0;
            green_r    <= 4'd0;
            blue_r     <= 4'd0;
            h_cnt      <= 10'd0;
            v_cnt      <= 10'd0;
            line_len   <= 10'd0;
            first_done <= 1'b0;
        end else begin
            hs_r    <= hsync_in;
            vs_r    <= vsync_in;
            hs_d    <= hs_r;
            vs_d    <= vs_r;
            red_r   <= red_in;
            green_r <= green_in;
            blue_r  <= blue_in;
            h_cnt   <= h_edge ? 10'd0 : h_len;
            if (v_edge)
                v_cnt <= 10'd0;
            else if (h_edge && v_cnt != 10'h3FF)
                v_cnt <= v_cnt + 10'd1;
            if (h_edge) begin
                line_len   <= h_len;
                first_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= SEARCH;
            mflag  <= 1'b0;
            locked <= 1'b0;
        end else begin
            case (state)
                SEARCH: begin
                    if (v_edge) begin
                        state <= CHECK;
                        mflag <= 1'b0;
                    end
                end
                CHECK: begin
                    if (v_edge) begin
                        if (!mflag && !len_bad && !frame_bad) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                        mflag <= 1'b0;
                    end else if (len_bad) begin
                        mflag <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (lock_fail) begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // Coordinates ride one stage alongside the registered colour so both reach the outputs together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vis1        <= 1'b0;
            x1          <= 10'd0;
            y1          <= 10'd0;
            pix_valid   <= 1'b0;
            pix_x       <= 10'd0;
            pix_y       <= 10'd0;
            pix_red     <= 4'd0;
            pix_green   <= 4'd0;
            pix_blue    <= 4'd0;
            frame_start <= 1'b0;
        end else begin
            vis1        <= h_vis && v_vis;
            x1          <= h_cnt - 10'(H_BP);
            y1          <= v_cnt - 10'(V_BP);
            pix_valid   <= out_ok;
            pix_x       <= out_ok ? x1 : 10'd0;
            pix_y       <= out_ok ? y1 : 10'd0;
            pix_red     <= out_ok ? red_r : 4'd0;
            pix_green   <= out_ok ? green_r : 4'd0;
            pix_blue    <= out_ok ? blue_r : 4'd0;
            frame_start <= out_ok && (x1 == 10'd0) && (y1 == 10'd0);
        end
    end

`ifdef VGA_DEC_STATS_EN
    logic err_evt;
    assign err_evt = ((state == CHECK) && (len_bad || frame_bad)) || lock_fail;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_count <= 8'd0;
        else if (err_evt && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down 16x10 timing.
// Pixel (x,y) of a frame is driven on line V_BP+y at cycle H_BP+2+x, where cycle 0 is the hsync rise.
module tb_vga_sync_decoder;
    localparam int HA = 8;
    localparam int HB = 3;
    localparam int HT = 16;
    localparam int VA = 4;
    localparam int VB = 2;
    localparam int VT = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync_in, vsync_in;
    logic [3:0] red_in, green_in, blue_in;
    logic       pix_valid;
    logic [9:0] pix_x, pix_y;
    logic [3:0] pix_red, pix_green, pix_blue;
    logic       frame_start;
    logic       locked;
    logic [9:0] line_len;
`ifdef VGA_DEC_STATS_EN
    logic [7:0] err_count;
    logic [7:0] err_snap;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_BP(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_BP(VB), .V_TOTAL(VT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hsync_in(hsync_in),
        .vsync_in(vsync_in),
        .red_in(red_in),
        .green_in(green_in),
        .blue_in(blue_in),
        .pix_valid(pix_valid),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .pix_red(pix_red),
        .pix_green(pix_green),
        .pix_blue(pix_blue),
        .frame_start(frame_start),
        .locked(locked),
        .line_len(line_len)
`ifdef VGA_DEC_STATS_EN
        ,
        .err_count(err_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic hs, input logic vs, input logic [3:0] r,
                         input logic [3:0] g, input logic [3:0] b);
        hsync_in = hs;
        vsync_in = vs;
        red_in   = r;
        green_in = g;
        blue_in  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, {pix_valid, pix_x, pix_y, pix_red, pix_green, pix_blue,
                  frame_start, locked, line_len}, 64'd0);
    endtask

    // Idle-high syncs, then a short low stretch so frame line 0 begins with a clean rise.
    task automatic preamble();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic run_frame(input int nlines, input int short_line, input bit exp_lock,
                             input int abort_line);
        bit          lock_now;
        int          fs_cnt;
        int          len;
        int          pc;
        bit          vis;
        logic [63:0] exp_v;
        lock_now = exp_lock;
        fs_cnt   = 0;
        for (int ln = 0; ln < nlines; ln++) begin
            len = (ln == short_line) ? HT - 1 : HT;
            if (short_line >= 0 && ln > short_line) lock_now = 1'b0;
            for (int c = 0; c < len; c++) begin
                if (ln == abort_line && c == 7) return;
                drive(c < len - 2, ln != nlines - 1, 4'(c + 5), 4'(ln), 4'(c ^ ln));
                if (c == 1) begin
                    if (ln == 0) chk("locked_at_vsync", locked, exp_lock);
                    else chk("line_len", line_len, (ln - 1 == short_line) ? HT - 1 : HT);
                    if (ln == short_line + 1 && short_line >= 0) begin
                        chk("locked_after_bad_line", locked, 0);
                        chk("pix_valid_after_bad_line", pix_valid, 0);
                    end
                end
                pc  = c - 1;
                vis = lock_now && ln >= VB && ln < VB + VA && pc >= HB + 2 && pc < HB + 2 + HA;
                exp_v = 64'd0;
                if (vis)
                    exp_v = {30'd0, 1'b1, 10'(pc - HB - 2), 10'(ln - VB), 4'(pc + 5), 4'(ln),
                             4'(pc ^ ln), (pc == HB + 2 && ln == VB)};
                if (frame_start) fs_cnt++;
                chk("pixel", {30'd0, pix_valid, pix_x, pix_y, pix_red, pix_green, pix_blue,
                              frame_start}, exp_v);
            end
        end
        chk("frame_start_count", fs_cnt, exp_lock ? 1 : 0);
    endtask

    initial begin
        reset    = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        red_in   = 4'hF;
        green_in = 4'hF;
        blue_in  = 4'hF;
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b1, 4'($urandom_range(1, 15)), 4'hF, 4'hF);
        check_all_zero("reset_outputs");
        reset = 1'b0;
        preamble();

        // First frame after reset is the CHECK frame; lock comes at the following vsync edge.
        run_frame(VT, -1, 1'b0, -1);
        chk("locked_before_lock_edge", locked, 0);
        run_frame(VT, -1, 1'b1, -1);
        run_frame(VT, -1, 1'b1, -1);

        // One line one cycle short while locked.
`ifdef VGA_DEC_STATS_EN
        err_snap = err_count;
`endif
        run_frame(VT, 4, 1'b1, -1);
`ifdef VGA_DEC_STATS_EN
        chk("err_count_short_line", err_count, err_snap + 8'd1);
`endif

        // SEARCH -> CHECK on a frame one line short: no lock at its end.
        run_frame(VT - 1, -1, 1'b0, -1);
`ifdef VGA_DEC_STATS_EN
        err_snap = err_count;
`endif
        run_frame(VT, -1, 1'b0, -1);
`ifdef VGA_DEC_STATS_EN
        chk("err_count_short_frame", err_count, err_snap + 8'd1);
`endif
        run_frame(VT, -1, 1'b1, -1);

        // Asynchronous reset in the middle of a visible line while locked.
        run_frame(VT, -1, 1'b1, 3);
        chk("pix_valid_before_reset", pix_valid, 1);
        chk("locked_before_reset", locked, 1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset_outputs");
`ifdef VGA_DEC_STATS_EN
        chk("err_count_reset", err_count, 0);
`endif
        drive(1'b1, 1'b1, 4'd0, 4'd0, 4'd0);
        drive(1'b1, 1'b1, 4'd0, 4'd0, 4'd0);
        check_all_zero("reset_held_outputs");
        reset = 1'b0;
        preamble();
        run_frame(VT, -1, 1'b0, -1);
        run_frame(VT, -1, 1'b1, -1);
        chk("locked_final", locked, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
